// File: rtl/npc_pkg.sv
// Shared types and field widths for the next-PC controller.
package npc_pkg;

    localparam int JT_W  = 26;
    localparam int IMM_W = 16;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_RD_WAIT = 2'b01,
        ST_WR_WAIT = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        BR_BEQ  = 2'b00,
        BR_BNE  = 2'b01,
        BR_BLEZ = 2'b10,
        BR_BGTZ = 2'b11
    } br_op_e;

    typedef enum logic [1:0] {
        J_SEQ  = 2'b00,
        J_JAL  = 2'b01,
        J_JR   = 2'b10,
        J_RSVD = 2'b11
    } jsel_e;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch-condition evaluator; rs/rt are treated as signed for BLEZ/BGTZ.
module branch_cmp
    import npc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            br_en,
    input  br_op_e          br_op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            taken
);

    logic rs_zero;
    logic rs_neg;

    assign rs_zero = (rs_val == '0);
    assign rs_neg  = rs_val[XLEN-1];

    always_comb begin
        taken = 1'b0;
        if (br_en) begin
            unique case (br_op)
                BR_BEQ:  taken = (rs_val == rt_val);
                BR_BNE:  taken = (rs_val != rt_val);
                BR_BLEZ: taken = rs_neg | rs_zero;
                BR_BGTZ: taken = ~rs_neg & ~rs_zero;
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/next_pc_ctrl.sv
// PC sequencer with branch/jump selection and data-memory wait stalls.
// Trap and exception-return support is compiled in with NPC_TRAP_EN.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_RUN     | PC advances on each valid instruction
// ST_RD_WAIT | read miss outstanding, PC held until mem_done
// ST_WR_WAIT | write outstanding, PC held until mem_done
module next_pc_ctrl
    import npc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
`ifdef NPC_TRAP_EN
    ,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0080)
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_en,
    input  logic             br_en,
    input  logic [1:0]       br_op,
    input  logic [XLEN-1:0]  rs_val,
    input  logic [XLEN-1:0]  rt_val,
    input  logic [IMM_W-1:0] imm16,
    input  logic [1:0]       jsel,
    input  logic [JT_W-1:0]  jtarget,
    input  logic [XLEN-1:0]  jr_val,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             mem_hit,
    input  logic             mem_done,
    input  logic             trap_req,
    input  logic             eret,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [XLEN-1:0]  epc,
    output logic             redirect,
    output logic             busy
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            redirect_q, redirect_d;

    logic            taken;
    logic            trap_hit;
    logic            eret_hit;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] jr_tgt;
    logic [XLEN-1:0] j_tgt;
    logic [XLEN-1:0] npc;
    logic            npc_redir;

`ifdef NPC_TRAP_EN
    assign trap_hit = trap_req;
    assign eret_hit = eret;
    assign trap_pc  = TRAP_VECTOR;
`else
    logic unused_trap;
    assign unused_trap = trap_req ^ eret;
    assign trap_hit    = 1'b0;
    assign eret_hit    = 1'b0;
    assign trap_pc     = '0;
`endif

    branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .br_en  (br_en),
        .br_op  (br_op_e'(br_op)),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .taken  (taken)
    );

    assign pc_plus4 = pc_q + PC_STEP;
    assign br_off   = {{(XLEN-IMM_W-2){imm16[IMM_W-1]}}, imm16, 2'b00};
    assign br_tgt   = pc_plus4 + br_off;
    assign jr_tgt   = jr_val & {{(XLEN-2){1'b1}}, 2'b00};
    assign j_tgt    = {pc_plus4[XLEN-1:28], jtarget, 2'b00};

    // Any selection other than the fall-through counts as a redirect, even if it lands on pc+4.
    always_comb begin
        npc       = pc_plus4;
        npc_redir = 1'b1;
        if (trap_hit) begin
            npc = trap_pc;
        end else if (eret_hit) begin
            npc = epc_q;
        end else if (jsel_e'(jsel) == J_JR) begin
            npc = jr_tgt;
        end else if (jsel_e'(jsel) == J_JAL) begin
            npc = j_tgt;
        end else if (taken) begin
            npc = br_tgt;
        end else begin
            npc_redir = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        if (trap_hit) begin
            state_d    = ST_RUN;
            epc_d      = pc_q;
            pc_d       = npc;
            redirect_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (pc_en) begin
                        if (mem_read && !mem_hit) begin
                            state_d = ST_RD_WAIT;
                        end else if (mem_write) begin
                            state_d = ST_WR_WAIT;
                        end else begin
                            pc_d       = npc;
                            redirect_d = npc_redir;
                        end
                    end
                end
                ST_RD_WAIT, ST_WR_WAIT: begin
                    if (mem_done) begin
                        state_d    = ST_RUN;
                        pc_d       = npc;
                        redirect_d = npc_redir;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_VECTOR;
            epc_q      <= '0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            redirect_q <= redirect_d;
        end
    end

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign redirect = redirect_q;
    assign busy     = (state_q != ST_RUN);

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Directed bench for next_pc_ctrl; trap cases follow NPC_TRAP_EN.
module tb_next_pc_ctrl;

    logic        clk;
    logic        reset;
    logic        pc_en;
    logic        br_en;
    logic [1:0]  br_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [15:0] imm16;
    logic [1:0]  jsel;
    logic [25:0] jtarget;
    logic [31:0] jr_val;
    logic        mem_read;
    logic        mem_write;
    logic        mem_hit;
    logic        mem_done;
    logic        trap_req;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        redirect;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    next_pc_ctrl #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc_en     (pc_en),
        .br_en     (br_en),
        .br_op     (br_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .imm16     (imm16),
        .jsel      (jsel),
        .jtarget   (jtarget),
        .jr_val    (jr_val),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_hit   (mem_hit),
        .mem_done  (mem_done),
        .trap_req  (trap_req),
        .eret      (eret),
        .pc        (pc),
        .pc_plus4  (pc_plus4),
        .epc       (epc),
        .redirect  (redirect),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        pc_en = 1'b1; br_en = 1'b0; br_op = 2'b00;
        rs_val = '0; rt_val = '0; imm16 = '0;
        jsel = 2'b00; jtarget = '0; jr_val = '0;
        mem_read = 1'b0; mem_write = 1'b0; mem_hit = 1'b0; mem_done = 1'b0;
        trap_req = 1'b0; eret = 1'b0;
    endtask

    task automatic set_pc(input logic [31:0] v);
        clr();
        jsel = 2'b10; jr_val = v;
        tick();
        chk("set_pc", {32'h0, pc}, {32'h0, v});
        clr();
    endtask

    task automatic br(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic [15:0] imm, input logic [31:0] exp_pc, input logic exp_rd,
                      input string tag);
        clr();
        br_en = 1'b1; br_op = op; rs_val = rs; rt_val = rt; imm16 = imm;
        tick();
        chk(tag, {32'h0, pc}, {32'h0, exp_pc});
        chk({tag, "_redir"}, {63'h0, redirect}, {63'h0, exp_rd});
        clr();
    endtask

    initial begin
        clr();
        reset = 1'b1;
        tick();
        tick();
        chk("rst_pc", {32'h0, pc}, 64'h0);
        chk("rst_pc4", {32'h0, pc_plus4}, 64'h4);
        chk("rst_epc", {32'h0, epc}, 64'h0);
        chk("rst_redir", {63'h0, redirect}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        reset = 1'b0;

        pc_en = 1'b0;
        tick();
        chk("hold_pc", {32'h0, pc}, 64'h0);
        pc_en = 1'b1;
        tick();
        chk("seq_pc", {32'h0, pc}, 64'h4);
        chk("seq_redir", {63'h0, redirect}, 64'h0);

        // reset while waiting on a read miss
        set_pc(32'h40);
        chk("jr_redir", {63'h0, redirect}, 64'h1);
        mem_read = 1'b1;
        tick();
        chk("rdw_busy", {63'h0, busy}, 64'h1);
        chk("rdw_pc", {32'h0, pc}, 64'h40);
        #2 reset = 1'b1;
        #1;
        chk("arst_pc", {32'h0, pc}, 64'h0);
        chk("arst_busy", {63'h0, busy}, 64'h0);
        tick();
        reset = 1'b0;
        clr();

        // read miss held for three cycles
        set_pc(32'h100);
        mem_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("miss_pc", {32'h0, pc}, 64'h100);
            chk("miss_busy", {63'h0, busy}, 64'h1);
            pc_en = 1'b0;
        end
        mem_done = 1'b1;
        tick();
        chk("done_pc", {32'h0, pc}, 64'h104);
        chk("done_busy", {63'h0, busy}, 64'h0);
        clr();
        mem_read = 1'b1; mem_hit = 1'b1;
        tick();
        chk("hit_pc", {32'h0, pc}, 64'h108);
        chk("hit_busy", {63'h0, busy}, 64'h0);
        clr();

        // branches
        set_pc(32'h200);
        br(2'b00, 32'd5, 32'd5, 16'hFFFF, 32'h200, 1'b1, "beq_t");
        br(2'b01, 32'd5, 32'd5, 16'hFFFF, 32'h204, 1'b0, "bne_nt");
        br(2'b10, 32'd0, 32'd0, 16'h0001, 32'h20C, 1'b1, "blez_zero");
        br(2'b11, 32'd0, 32'd0, 16'h0001, 32'h210, 1'b0, "bgtz_zero");
        br(2'b11, 32'd1, 32'd0, 16'h0002, 32'h21C, 1'b1, "bgtz_pos");
        br(2'b10, 32'h8000_0000, 32'd0, 16'h0010, 32'h260, 1'b1, "blez_neg");
        clr();
        rs_val = 32'd7; rt_val = 32'd7; imm16 = 16'h0010;
        tick();
        chk("br_dis", {32'h0, pc}, 64'h264);

        // jumps
        set_pc(32'h1000_0010);
        jsel = 2'b01; jtarget = 26'h000_0040;
        tick();
        chk("j_pc", {32'h0, pc}, 64'h1000_0100);
        chk("j_redir", {63'h0, redirect}, 64'h1);
        clr();
        jsel = 2'b10; jr_val = 32'h333;
        br_en = 1'b1; rs_val = 32'd1; rt_val = 32'd1; imm16 = 16'h0100;
        tick();
        chk("jr_pc", {32'h0, pc}, 64'h330);
        clr();
        jsel = 2'b11; br_en = 1'b1; rs_val = 32'd3; rt_val = 32'd3; imm16 = 16'h0001;
        tick();
        chk("jrsvd_br", {32'h0, pc}, 64'h338);
        clr();

        // write stall
        mem_write = 1'b1;
        tick();
        chk("wr_busy", {63'h0, busy}, 64'h1);
        chk("wr_pc", {32'h0, pc}, 64'h338);
        mem_done = 1'b1;
        tick();
        chk("wr_done", {32'h0, pc}, 64'h33C);
        chk("wr_done_busy", {63'h0, busy}, 64'h0);
        clr();

        // wrap
        set_pc(32'hFFFF_FFFC);
        chk("wrap_pc4", {32'h0, pc_plus4}, 64'h0);
        tick();
        chk("wrap_pc", {32'h0, pc}, 64'h0);

`ifdef NPC_TRAP_EN
        set_pc(32'h500);
        mem_write = 1'b1;
        tick();
        chk("tw_busy", {63'h0, busy}, 64'h1);
        clr();
        mem_write = 1'b1; trap_req = 1'b1;
        tick();
        chk("trap_epc", {32'h0, epc}, 64'h500);
        chk("trap_pc", {32'h0, pc}, 64'h80);
        chk("trap_busy", {63'h0, busy}, 64'h0);
        chk("trap_redir", {63'h0, redirect}, 64'h1);
        clr();
        eret = 1'b1;
        tick();
        chk("eret_pc", {32'h0, pc}, 64'h500);
        chk("eret_redir", {63'h0, redirect}, 64'h1);
        clr();
        trap_req = 1'b1; eret = 1'b1;
        tick();
        chk("both_pc", {32'h0, pc}, 64'h80);
        chk("both_epc", {32'h0, epc}, 64'h500);
        clr();
`else
        set_pc(32'h500);
        trap_req = 1'b1;
        tick();
        chk("notrap_pc", {32'h0, pc}, 64'h504);
        chk("notrap_epc", {32'h0, epc}, 64'h0);
        clr();
        eret = 1'b1;
        tick();
        chk("noeret_pc", {32'h0, pc}, 64'h508);
        chk("noeret_redir", {63'h0, redirect}, 64'h0);
        clr();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/next_pc_ctrl.md
NEXT_PC_CTRL -- requirements
Module: next_pc_ctrl

Interface
REQ-001 Parameter XLEN, default 32, PC/datapath width; legal values 32 and 64.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter TRAP_VECTOR, default 32'h0000_0080, PC value loaded on trap; present only when trap support is compiled in.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 pc_en  in  1  current instruction valid; PC may advance.
REQ-007 br_en  in  1  current instruction is a conditional branch.
REQ-008 br_op  in  2  branch condition: 00 BEQ, 01 BNE, 10 BLEZ, 11 BGTZ.
REQ-009 rs_val, rt_val  in  XLEN  branch comparison operands.
REQ-010 imm16  in  16  branch offset, in words.
REQ-011 jsel  in  2  jump select: 00 sequential/branch, 01 J/JAL, 10 JR, 11 reserved.
REQ-012 jtarget  in  26  J-format target field.
REQ-013 jr_val  in  XLEN  JR register operand.
REQ-014 mem_read, mem_write, mem_hit, mem_done  in  1 each  data-memory status for the current instruction.
REQ-015 trap_req, eret  in  1 each  trap request and exception return.
REQ-016 pc, pc_plus4  out  XLEN  current PC and PC+4.
REQ-017 epc  out  XLEN  saved exception PC.
REQ-018 redirect  out  1  one-cycle pulse on any non-sequential PC update.
REQ-019 busy  out  1  high while the FSM is not in RUN.

Function
REQ-020 FSM states RUN, RD_WAIT and WR_WAIT.
REQ-021 In RUN with pc_en=1: mem_read=1 and mem_hit=0 moves to RD_WAIT with PC held; mem_write=1 moves to WR_WAIT with PC held; otherwise PC <= next-PC.
REQ-022 RD_WAIT and WR_WAIT hold PC until mem_done=1, then load next-PC and return to RUN on the same edge; a done edge is a single-cycle update.
REQ-023 Instruction inputs remain stable while busy=1; the block does not latch them.
REQ-024 Next-PC priority: trap, eret, jsel=10 (jr_val with bits[1:0] forced to 0), jsel=01 ({pc_plus4[XLEN-1:28], jtarget, 2'b00}), taken branch (pc_plus4 + (sign-extended imm16 << 2)), pc_plus4.
REQ-025 jsel=11 behaves as jsel=00.
REQ-026 Branch taken: BEQ rs==rt; BNE rs!=rt; BLEZ signed rs<=0; BGTZ signed rs>0; br_en=0 means not taken.
REQ-027 All additions are modulo 2^XLEN; PC wraps from all-ones-minus-3 to 0.
REQ-028 redirect=1 on the cycle after any PC load that is not pc_plus4, including trap and eret.
REQ-029 pc_en=0 in RUN holds PC with no state change; pc_en is ignored in the wait states.

Reset
REQ-030 While reset is high: pc=RESET_VECTOR, epc=0, redirect=0, busy=0, state=RUN, asynchronously and including mid-wait.

Configuration
REQ-031 Macro NPC_TRAP_EN defined: trap_req has priority in every state, sets epc<=pc and pc<=TRAP_VECTOR, and forces RUN, aborting any wait; eret in RUN with pc_en=1 loads pc<=epc; trap_req and eret together means trap wins.
REQ-032 NPC_TRAP_EN undefined: trap_req and eret are ignored, epc is tied to 0, and TRAP_VECTOR is unused.

Structure
REQ-033 Package npc_pkg holds the state enum, br_op and jsel enums, and the width constants 26/16.
REQ-034 Sub-module branch_cmp(XLEN) computes the taken flag combinationally; everything else is in next_pc_ctrl.

Verification
REQ-035 Reset mid-RD_WAIT: pc 0x40 busy, assert reset -> pc=0x0, busy=0 immediately.
REQ-036 Read miss: pc=0x100, mem_read=1, mem_hit=0 for 3 cycles, then mem_done -> pc holds 0x100 for 3 cycles, then 0x104, busy falls on the same edge.
REQ-037 BEQ taken: pc=0x200, rs=rt=5, imm16=0xFFFF -> pc=0x200, redirect=1 next cycle; BNE same operands -> pc=0x204.
REQ-038 J at pc=0x1000_0010, jtarget=0x000_0040 -> pc=0x1000_0100; JR jr_val=0x333 -> pc=0x330.
REQ-039 Wrap: XLEN=32, pc=0xFFFF_FFFC sequential -> pc=0x0.
REQ-040 NPC_TRAP_EN, trap_req in WR_WAIT at pc=0x500 -> epc=0x500, pc=0x80, busy=0; eret -> pc=0x500.
